// File: rtl/instr_reader_pkg.sv
// Shared instruction-register types: addresses, opcodes, stored instruction
// layout, the read-run count and the reader FSM states.
package instr_reader_pkg;

    localparam int ADDR_W = 6;
    localparam int OPND_W = 32;
    localparam int RES_W  = 64;

    typedef logic [ADDR_W-1:0] address_t;
    typedef logic [6:0]        count_t;

    typedef enum logic [3:0] {
        OPC_ZERO  = 4'd0,
        OPC_PASSA = 4'd1,
        OPC_PASSB = 4'd2,
        OPC_ADD   = 4'd3,
        OPC_SUB   = 4'd4,
        OPC_MULT  = 4'd5,
        OPC_DIV   = 4'd6,
        OPC_MOD   = 4'd7
    } opcode_t;

    // Encodings above this are reserved and execute as errors.
    localparam opcode_t MAX_LEGAL_OPC = OPC_MOD;

    typedef struct packed {
        opcode_t                  opc;
        address_t                 r;
        logic signed [OPND_W-1:0] op_a;
        logic signed [OPND_W-1:0] op_b;
    } instruction_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_EXEC  = ST_EXEC,
        S_OUT   = ST_OUT
    } state_t;

    function automatic logic opc_legal(input opcode_t opc);
        return opc <= MAX_LEGAL_OPC;
    endfunction

endpackage

// File: rtl/instr_reader_alu.sv
// Combinational 64-bit signed executor for one stored instruction.
module instr_alu
    import instr_reader_pkg::*;
(
    input  opcode_t                  opc,
    input  logic signed [OPND_W-1:0] op_a,
    input  logic signed [OPND_W-1:0] op_b,
    output logic signed [RES_W-1:0]  result,
    output logic                     err
);

    logic signed [RES_W-1:0] a;
    logic signed [RES_W-1:0] b;

    assign a = {{(RES_W-OPND_W){op_a[OPND_W-1]}}, op_a};
    assign b = {{(RES_W-OPND_W){op_b[OPND_W-1]}}, op_b};

    always_comb begin
        result = '0;
        err    = 1'b0;
        if (!opc_legal(opc)) begin
            err = 1'b1;
        end else begin
            case (opc)
                OPC_ZERO:  result = '0;
                OPC_PASSA: result = a;
                OPC_PASSB: result = b;
                OPC_ADD:   result = a + b;
                OPC_SUB:   result = a - b;
                OPC_MULT:  result = a * b;
                // Signed / and % truncate toward zero; remainder follows the dividend.
                OPC_DIV:   if (b == '0) err = 1'b1; else result = a / b;
                OPC_MOD:   if (b == '0) err = 1'b1; else result = a % b;
                default:   result = '0;
            endcase
        end
    end

endmodule

// File: rtl/instr_reader.sv
// Walks a contiguous address range of the instruction register, executes each
// stored instruction and streams address/opcode/result out on valid/ready.
module instr_reader
    import instr_reader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  address_t                first_addr,
    input  count_t                  count,
    output address_t                read_pointer,
    input  instruction_t            instr_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output address_t                out_addr,
    output opcode_t                 out_opc,
    output logic signed [RES_W-1:0] out_result,
    output logic                    out_err,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state
);

    // Output stream: a beat transfers on a rising edge where out_valid and
    // out_ready are both high; until then every out_* signal is held stable.

    state_t                   state;
    count_t                   remaining;
    opcode_t                  cap_opc;
    logic signed [OPND_W-1:0] cap_a;
    logic signed [OPND_W-1:0] cap_b;
    logic signed [RES_W-1:0]  alu_result;
    logic                     alu_err;
    logic                     unused_r;

    // The destination field is not needed on the read path.
    assign unused_r  = ^instr_word.r;
    assign dbg_state = state;

    instr_alu u_alu (
        .opc    (cap_opc),
        .op_a   (cap_a),
        .op_b   (cap_b),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            read_pointer <= '0;
            remaining    <= '0;
            cap_opc      <= OPC_ZERO;
            cap_a        <= '0;
            cap_b        <= '0;
            out_valid    <= 1'b0;
            out_addr     <= '0;
            out_opc      <= OPC_ZERO;
            out_result   <= '0;
            out_err      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            read_pointer <= first_addr;
                            remaining    <= count;
                            busy         <= 1'b1;
                            state        <= S_FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    cap_opc <= instr_word.opc;
                    cap_a   <= instr_word.op_a;
                    cap_b   <= instr_word.op_b;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    out_addr   <= read_pointer;
                    out_opc    <= cap_opc;
                    out_result <= alu_result;
                    out_err    <= alu_err;
                    out_valid  <= 1'b1;
                    state      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (remaining > count_t'(1)) begin
                            remaining    <= remaining - count_t'(1);
                            read_pointer <= read_pointer + address_t'(1);
                            state        <= S_FETCH;
                        end else begin
                            remaining <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_reader.sv
// Bench for instr_reader: directed scenarios plus randomized runs, checked
// every cycle against a queue-based model of the read/execute stream.
module tb_instr_reader;
    import instr_reader_pkg::*;

    localparam int BW = 75;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    address_t                first_addr;
    count_t                  count;
    address_t                read_pointer;
    instruction_t            instr_word;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    address_t                out_addr;
    opcode_t                 out_opc;
    logic signed [63:0]      out_result;
    logic                    out_err;
    logic                    busy;
    logic                    done;
    logic [1:0]              dbg_state;

    instruction_t mem [64];
    assign instr_word = mem[read_pointer];

    instr_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .first_addr   (first_addr),
        .count        (count),
        .read_pointer (read_pointer),
        .instr_word   (instr_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_opc      (out_opc),
        .out_result   (out_result),
        .out_err      (out_err),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [BW-1:0] exp_q[$];
    bit       check_en = 1'b0;
    bit       model_busy = 1'b0;
    bit       model_valid = 1'b0;
    int       countdown = 0;
    address_t model_rp = '0;
    bit       exp_done = 1'b0;
    int       hs_count = 0;
    bit       prev_hold = 1'b0;
    logic [BW-1:0] prev_beat;
    int       ready_mode = 0;
    longint   got_res[$];
    logic     got_err[$];
    address_t got_addr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics of one instruction.
    function automatic void model_exec(input logic [3:0] opc, input int a, input int b,
                                       output longint r, output logic e);
        longint la;
        longint lb;
        la = a;
        lb = b;
        r  = 0;
        e  = 1'b0;
        case (opc)
            4'd0: r = 0;
            4'd1: r = la;
            4'd2: r = lb;
            4'd3: r = la + lb;
            4'd4: r = la - lb;
            4'd5: r = la * lb;
            4'd6: if (lb == 0) e = 1'b1; else r = la / lb;
            4'd7: if (lb == 0) e = 1'b1; else r = la % lb;
            default: e = 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // scoreboard: one compare per cycle, then advance the model
    always @(negedge clk) begin
        logic [BW-1:0] cur;
        logic [BW-1:0] e;
        address_t      a;
        instruction_t  w;
        longint        r;
        logic          er;
        if (check_en) begin
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) model_valid = 1'b1;
            end
            chk("out_valid", out_valid, model_valid);
            chk("busy", busy, model_busy);
            chk("done", done, exp_done);
            chk("read_pointer", read_pointer, model_rp);
            cur = {out_addr, 4'(out_opc), out_result, out_err};
            if (out_valid && model_valid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_pending", 0, 1);
                end else begin
                    e = exp_q[0];
                    chk("out_addr", out_addr, e[74:69]);
                    chk("out_opc", 4'(out_opc), e[68:65]);
                    chk("out_result", out_result, e[64:1]);
                    chk("out_err", out_err, e[0]);
                end
            end
            if (prev_hold && out_valid) chk("held_stable", cur == prev_beat, 1);
            exp_done = 1'b0;
            if (reset) begin
                exp_q.delete();
                model_busy  = 1'b0;
                model_valid = 1'b0;
                countdown   = 0;
                model_rp    = '0;
                prev_hold   = 1'b0;
            end else begin
                prev_hold = out_valid && !out_ready;
                prev_beat = cur;
                if (model_valid && out_ready) begin
                    hs_count++;
                    got_res.push_back(out_result);
                    got_err.push_back(out_err);
                    got_addr.push_back(out_addr);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    model_valid = 1'b0;
                    if (exp_q.size() == 0) begin
                        model_busy = 1'b0;
                        exp_done   = 1'b1;
                    end else begin
                        model_rp  = model_rp + address_t'(1);
                        countdown = 3;
                    end
                end else if (start && !model_busy) begin
                    if (count == '0) begin
                        exp_done = 1'b1;
                    end else begin
                        model_busy = 1'b1;
                        model_rp   = first_addr;
                        countdown  = 3;
                        for (int i = 0; i < int'(count); i++) begin
                            a = address_t'(int'(first_addr) + i);
                            w = mem[a];
                            model_exec(4'(w.opc), w.op_a, w.op_b, r, er);
                            exp_q.push_back({a, 4'(w.opc), r, er});
                        end
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic set_instr(input int addr, input logic [3:0] o, input int x, input int y);
        mem[addr] = '{opc: opcode_t'(o), r: 6'($urandom), op_a: x, op_b: y};
    endtask

    function automatic int rand_opnd();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return $urandom_range(0, 40) - 20;
            default: return int'($urandom);
        endcase
    endfunction

    task automatic pulse_start(input int fa, input int cnt);
        @(posedge clk);
        #1;
        start      = 1'b1;
        first_addr = address_t'(fa);
        count      = count_t'(cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < budget);
        if (busy || exp_q.size() != 0) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic clear_got();
        got_res.delete();
        got_err.delete();
        got_addr.delete();
    endtask

    task automatic chk_res4(input string name, input longint e0, input longint e1,
                            input longint e2, input longint e3);
        longint ev [4];
        ev = '{e0, e1, e2, e3};
        chk({name, "_beats"}, got_res.size(), 4);
        for (int i = 0; i < 4 && i < got_res.size(); i++) chk(name, got_res[i], ev[i]);
    endtask

    task automatic load_basic();
        set_instr(0, 4'd3, 5, 7);
        set_instr(1, 4'd4, 3, 10);
        set_instr(2, 4'd5, -4, 100000);
        set_instr(3, 4'd2, 0, -1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint r;
        logic   er;
        int     n;
        int     hs_base;
        reset      = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        count      = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // model pins
        model_exec(4'd3, 5, 7, r, er);       chk("pin_add", r, 12);
        model_exec(4'd6, -7, 2, r, er);      chk("pin_div", r, -3);
        model_exec(4'd7, -7, 2, r, er);      chk("pin_mod", r, -1);
        model_exec(4'd6, 9, 0, r, er);       chk("pin_div0", {r[62:0], er}, 1);
        model_exec(4'd12, 3, 4, r, er);      chk("pin_illegal", {r[62:0], er}, 1);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_read_pointer", read_pointer, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_opc", 4'(out_opc), 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        check_en = 1'b1;

        // zero-length run
        pulse_start(5, 0);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        @(negedge clk);
        chk("zero_done_clear", done, 0);
        chk("zero_no_valid", out_valid, 0);

        // basic run
        load_basic();
        clear_got();
        pulse_start(0, 4);
        wait_idle(200);
        chk_res4("basic", 12, -7, -400000, -1);

        // division/modulo and illegal opcode
        set_instr(10, 4'd6, -7, 2);
        set_instr(11, 4'd7, -7, 2);
        set_instr(12, 4'd6, 9, 0);
        set_instr(13, 4'd12, 1, 1);
        clear_got();
        pulse_start(10, 4);
        wait_idle(200);
        chk_res4("divmod", -3, -1, 0, 0);
        for (int i = 0; i < 4 && i < got_err.size(); i++) chk("divmod_err", got_err[i], (i >= 2));

        // backpressure on the first beat
        clear_got();
        ready_mode = 2;
        pulse_start(10, 4);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_first_valid", out_valid, 1);
        repeat (10) @(negedge clk);
        chk("bp_hold_rp", read_pointer, 10);
        chk("bp_hold_addr", out_addr, 10);
        @(posedge clk);
        #1 ready_mode = 0;
        wait_idle(200);
        chk_res4("bp", -3, -1, 0, 0);

        // address wrap
        set_instr(62, 4'd1, 62, 0);
        set_instr(63, 4'd1, 63, 0);
        set_instr(0, 4'd1, 100, 0);
        set_instr(1, 4'd1, 101, 0);
        clear_got();
        pulse_start(62, 4);
        wait_idle(200);
        chk_res4("wrap", 62, 63, 100, 101);
        for (int i = 0; i < 4 && i < got_addr.size(); i++) chk("wrap_addr", got_addr[i], (62 + i) % 64);

        // reset while the second beat is waiting
        load_basic();
        hs_base = hs_count;
        pulse_start(0, 4);
        n = 0;
        while (hs_count < hs_base + 1 && n < 50) begin @(negedge clk); n++; end
        chk("rst_run_first_hs", hs_count >= hs_base + 1, 1);
        @(posedge clk);
        #1 ready_mode = 2;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("rst_run_second_valid", out_valid, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        ready_mode = 0;
        clear_got();
        pulse_start(0, 4);
        wait_idle(200);
        chk_res4("after_abort", 12, -7, -400000, -1);

        // randomized runs
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 64; i++)
                set_instr(i, 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
            ready_mode = 1;
            pulse_start($urandom_range(0, 63), (k == 0) ? 64 : $urandom_range(0, 9));
            if (k % 3 == 0) begin
                repeat ($urandom_range(0, 12)) @(posedge clk);
                pulse_start($urandom_range(0, 63), $urandom_range(0, 5));
            end
            wait_idle(3000);
        end
        ready_mode = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
